avg_window: RTL and testbench
=============================

Name: avg_window

Overview:
- Parametrised successor to the team's four-sample averager.
- Accepts samples on an asynchronous data_ready strobe and keeps a circular buffer of the last 2^LOG2_DEPTH samples with a running sum.
- Supports two modes: sliding-window average, and non-overlapping block average.
- Sits between the sample source and the output register, and also provides a sample counter, a busy flag and a dropped-sample error.

Parameters:
- DATA_W, 16, sample and average width in bits (unsigned).
- LOG2_DEPTH, 2, log2 of the window depth; DEPTH = 2^LOG2_DEPTH, legal range 1..6.
- COUNT_MAX, 1000, number of accepted samples per one_k_samples pulse (>= 1).

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  reset, synchronous and active-high.
- data_ready  in  1  asynchronous sample strobe; level, held >= 2 clk cycles.
- sample_data  in  DATA_W  sample value; stable while data_ready is high.
- mode  in  1  0 = sliding window, 1 = block average.
- modwait  out  1  high while a sample is being processed.
- avg_out  out  DATA_W  current average, registered.
- avg_valid  out  1  one-cycle pulse when avg_out updates.
- one_k_samples  out  1  one-cycle pulse every COUNT_MAX accepted samples.
- err  out  1  high after a dropped sample; cleared by the next accepted sample.

Behaviour:
- Reset (synchronous, highest priority, any state):
  - modwait, avg_out, avg_valid, one_k_samples and err go to 0.
  - Buffer entries, running sum, write pointer, block phase and sample counter go to 0.
  - Synchroniser flops go to 0 and mode_q goes to 0.
  - Reset mid-operation abandons the sample in progress; no partial update.
- Input path:
  - data_ready passes through 2 flops, then a rising-edge detect, giving the pulse dr_pulse.
  - dr_pulse asserts 3 clk edges after data_ready is first sampled high.
- FSM states:
  - IDLE -> LOAD on dr_pulse. This is the accept edge A: sample_data and mode are captured.
  - LOAD: oldest = buf[wr_ptr]; buf[wr_ptr] <= sample. If mode != mode_q, first zero all buffer entries, sum and block phase, then update mode_q. Goes to ACCUM.
  - ACCUM: sum <= sum + sample - oldest, with sum width DATA_W+LOG2_DEPTH, so no overflow or underflow is possible. wr_ptr increments modulo DEPTH. Goes to IDLE.
- Timing: modwait is high in LOAD and ACCUM, i.e. after edges A and A+1. It is registered, so it is low the cycle after A+2.
- Sliding mode (mode=0):
  - Edge A+2: avg_out <= new_sum >> LOG2_DEPTH (truncating) and avg_valid pulses.
  - Before the buffer fills, empty entries count as 0.
- Block mode (mode=1):
  - block phase counts 0..DEPTH-1.
  - On the DEPTH-th sample of a block: avg_out <= new_sum >> LOG2_DEPTH and avg_valid pulses at A+2. Sum, buffer and phase then clear.
  - Other samples: avg_out holds and avg_valid stays 0.
- Dropped sample: dr_pulse while in LOAD or ACCUM drops the sample, sets err at the next edge and leaves state unchanged. err holds until the next accepted sample (cleared at that sample's edge A).
- Sample counter:
  - Increments at A+2 for every accepted sample.
  - When it reaches COUNT_MAX it wraps to 0 and one_k_samples pulses for that cycle.
  - Dropped samples do not count.
- Simultaneous events: a dr_pulse on the same cycle as the FSM returning to IDLE is accepted, giving back-to-back processing.

Test Plan:
- Reset during ACCUM with sum nonzero -> next cycle all outputs 0; a new sample 8 (DEPTH=4, sliding) gives avg_out=2, confirming sum and buffer were cleared.
- Sliding, DEPTH=4, samples 4, 8, 12, 16, 20 -> avg_out 1, 3, 6, 10, 14; avg_valid pulses 5 times; modwait high exactly 2 cycles per sample.
- Block, DEPTH=4, samples 100, 200, 300, 400, 10 -> single avg_valid with avg_out=250 after the 4th sample; avg_out holds 250 after 10. Switching to mode=0 then sample 40 -> avg_out=10 (buffer cleared on mode change).
- Width limit: four samples of 0xFFFF -> avg_out=0xFFFF with no wrap. A fifth sample of 0x0000 -> avg_out=0xBFFF.
- Dropped sample: second data_ready edge arriving while modwait=1 -> err=1, avg_out unaffected by the dropped value. Next accepted sample -> err=0 at its accept edge.
- COUNT_MAX=5 override: 5 accepted samples -> one_k_samples high exactly one cycle at the 5th sample's A+2, counter wraps. An interleaved dropped sample does not advance the count.

Source files
------------

// File: rtl/avg_window.sv
// Windowed sample averager: sliding or non-overlapping block average over 2^LOG2_DEPTH samples,
// with a synchronised sample strobe, sample counter, busy flag and dropped-sample error.
module avg_window #(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned LOG2_DEPTH = 2,
  parameter int unsigned COUNT_MAX  = 1000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              data_ready,
  input  logic [DATA_W-1:0] sample_data,
  input  logic              mode,
  output logic              modwait,
  output logic [DATA_W-1:0] avg_out,
  output logic              avg_valid,
  output logic              one_k_samples,
  output logic              err
);

  localparam int unsigned Depth = 1 << LOG2_DEPTH;
  localparam int unsigned SumW  = DATA_W + LOG2_DEPTH;
  localparam int unsigned CntW  = (COUNT_MAX > 1) ? $clog2(COUNT_MAX) : 1;

  typedef enum logic [1:0] {StIdle, StLoad, StAccum} state_e;

  state_e                 state_q;
  logic                   sync1_q, sync2_q, sync3_q;
  logic [DATA_W-1:0]      mem_q [Depth];
  logic [DATA_W-1:0]      sample_q;
  logic [DATA_W-1:0]      oldest_q;
  logic [SumW-1:0]        sum_q;
  logic [LOG2_DEPTH-1:0]  wr_ptr_q;
  logic [LOG2_DEPTH-1:0]  phase_q;
  logic [CntW-1:0]        cnt_q;
  logic                   mode_q;
  logic                   mode_new_q;

  logic                   dr_pulse;
  logic [SumW-1:0]        new_sum;

  assign dr_pulse = sync2_q & ~sync3_q;
  // sum_q already contains oldest_q, so the subtraction cannot underflow.
  assign new_sum  = sum_q + SumW'(sample_q) - SumW'(oldest_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      sync1_q       <= 1'b0;
      sync2_q       <= 1'b0;
      sync3_q       <= 1'b0;
      for (int i = 0; i < Depth; i++) mem_q[i] <= '0;
      sample_q      <= '0;
      oldest_q      <= '0;
      sum_q         <= '0;
      wr_ptr_q      <= '0;
      phase_q       <= '0;
      cnt_q         <= '0;
      mode_q        <= 1'b0;
      mode_new_q    <= 1'b0;
      modwait       <= 1'b0;
      avg_out       <= '0;
      avg_valid     <= 1'b0;
      one_k_samples <= 1'b0;
      err           <= 1'b0;
    end else begin
      sync1_q       <= data_ready;
      sync2_q       <= sync1_q;
      sync3_q       <= sync2_q;
      avg_valid     <= 1'b0;
      one_k_samples <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (dr_pulse) begin
            sample_q   <= sample_data;
            mode_new_q <= mode;
            err        <= 1'b0;
            modwait    <= 1'b1;
            state_q    <= StLoad;
          end
        end
        StLoad: begin
          if (dr_pulse) err <= 1'b1;
          if (mode_new_q != mode_q) begin
            for (int i = 0; i < Depth; i++) mem_q[i] <= '0;
            sum_q    <= '0;
            phase_q  <= '0;
            oldest_q <= '0;
            mode_q   <= mode_new_q;
          end else begin
            oldest_q <= mem_q[wr_ptr_q];
          end
          // Placed after the clear loop so the new sample survives a mode change.
          mem_q[wr_ptr_q] <= sample_q;
          state_q         <= StAccum;
        end
        StAccum: begin
          if (dr_pulse) err <= 1'b1;
          wr_ptr_q <= wr_ptr_q + 1'b1;
          modwait  <= 1'b0;
          state_q  <= StIdle;
          if (cnt_q == CntW'(COUNT_MAX - 1)) begin
            cnt_q         <= '0;
            one_k_samples <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
          if (!mode_q) begin
            sum_q     <= new_sum;
            avg_out   <= new_sum[SumW-1:LOG2_DEPTH];
            avg_valid <= 1'b1;
          end else if (phase_q == LOG2_DEPTH'(Depth - 1)) begin
            avg_out   <= new_sum[SumW-1:LOG2_DEPTH];
            avg_valid <= 1'b1;
            sum_q     <= '0;
            phase_q   <= '0;
            for (int i = 0; i < Depth; i++) mem_q[i] <= '0;
          end else begin
            sum_q   <= new_sum;
            phase_q <= phase_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_avg_window.sv
// Randomised self-checking bench for avg_window: a queue-based window model predicts a per-cycle
// expected waveform which one compare process checks every cycle, plus literal spot checks.
module tb_avg_window;
  localparam int unsigned Depth = 4;
  localparam int unsigned CMax  = 5;
  localparam int          MaxE  = 8192;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        data_ready = 1'b0;
  logic [15:0] sample_data = '0;
  logic        mode = 1'b0;
  logic        modwait, avg_valid, one_k_samples, err;
  logic [15:0] avg_out;

  avg_window #(.DATA_W(16), .LOG2_DEPTH(2), .COUNT_MAX(CMax)) dut (
    .clk(clk), .reset(reset), .data_ready(data_ready), .sample_data(sample_data), .mode(mode),
    .modwait(modwait), .avg_out(avg_out), .avg_valid(avg_valid),
    .one_k_samples(one_k_samples), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  // Expected waveform, indexed by the number of rising edges seen.
  bit          rst_at  [MaxE];
  bit          mw_e    [MaxE];
  bit          valid_e [MaxE];
  bit          onek_e  [MaxE];
  bit          set_avg [MaxE];
  bit          set_err [MaxE];
  bit          clr_err [MaxE];
  logic [15:0] avg_e   [MaxE];

  // Behavioural model state.
  int unsigned win[$];
  bit          m_mode = 1'b0;
  int          m_count = 0;

  bit          armed = 1'b0;
  logic [15:0] lvl_avg = '0;
  logic        lvl_err = 1'b0;
  int          nvalid = 0;
  int          nonek = 0;
  bit          overrun = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic bit in_range(input int n);
    return (n >= 0) && (n < MaxE);
  endfunction

  // Predict the effect of a sample accepted at edge a.
  task automatic accept(input int a, input logic [15:0] v, input bit m);
    longint s;
    if (!in_range(a + 2)) return;
    clr_err[a] = 1'b1;
    mw_e[a] = 1'b1;
    mw_e[a + 1] = 1'b1;
    if (m != m_mode) begin
      win.delete();
      m_mode = m;
    end
    win.push_back(v);
    if (!m && win.size() > Depth) void'(win.pop_front());
    if (!m || win.size() == Depth) begin
      s = 0;
      foreach (win[i]) s += win[i];
      valid_e[a + 2] = 1'b1;
      set_avg[a + 2] = 1'b1;
      avg_e[a + 2]   = 16'(s / Depth);
      if (m) win.delete();
    end
    m_count++;
    if (m_count == CMax) begin
      m_count = 0;
      onek_e[a + 2] = 1'b1;
    end
  endtask

  task automatic do_reset();
    int n;
    @(negedge clk);
    reset = 1'b1;
    data_ready = 1'b0;
    n = cyc + 1;
    for (int i = n; i < MaxE; i++) begin
      rst_at[i] = 0; mw_e[i] = 0; valid_e[i] = 0; onek_e[i] = 0;
      set_avg[i] = 0; set_err[i] = 0; clr_err[i] = 0;
    end
    if (in_range(n)) rst_at[n] = 1'b1;
    win.delete();
    m_mode = 1'b0;
    m_count = 0;
    @(negedge clk);
    reset = 1'b0;
    armed = 1'b1;
  endtask

  task automatic send(input logic [15:0] v, input bit m, input int hold, input bit settle);
    int e1;
    @(negedge clk);
    e1 = cyc + 1;
    accept(e1 + 2, v, m);
    data_ready = 1'b1;
    sample_data = v;
    mode = m;
    repeat (hold) @(negedge clk);
    data_ready = 1'b0;
    if (settle) repeat (6) @(negedge clk);
  endtask

  // Two strobes whose rising edges are gap cycles apart: gap 2 lands the second
  // pulse while busy (dropped), gap 3 lands it just as the FSM is idle again.
  task automatic pair(input logic [15:0] v1, input logic [15:0] v2, input bit m, input int gap);
    int e1, r;
    @(negedge clk);
    e1 = cyc + 1;
    accept(e1 + 2, v1, m);
    if (gap == 2) begin
      if (in_range(e1 + 4)) set_err[e1 + 4] = 1'b1;
    end else begin
      accept(e1 + gap + 2, v2, m);
    end
    for (int k = 0; k < gap + 2; k++) begin
      if (k > 0) @(negedge clk);
      r = cyc + 1 - e1;
      data_ready = (r < gap - 1) || (r >= gap);
      sample_data = (r <= 2) ? v1 : v2;
      mode = m;
    end
    @(negedge clk);
    data_ready = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (armed) begin
      if (cyc >= MaxE) begin
        if (!overrun) begin
          overrun = 1'b1;
          check("cycle_budget", 32'(cyc), 32'(MaxE - 1));
        end
      end else begin
        if (rst_at[cyc]) begin
          lvl_avg = '0;
          lvl_err = 1'b0;
        end else begin
          if (set_avg[cyc]) lvl_avg = avg_e[cyc];
          if (set_err[cyc]) lvl_err = 1'b1;
          if (clr_err[cyc]) lvl_err = 1'b0;
        end
        check("avg_out", 32'(avg_out), 32'(lvl_avg));
        check("avg_valid", 32'(avg_valid), 32'(valid_e[cyc]));
        check("modwait", 32'(modwait), 32'(mw_e[cyc]));
        check("one_k_samples", 32'(one_k_samples), 32'(onek_e[cyc]));
        check("err", 32'(err), 32'(lvl_err));
        if (avg_valid === 1'b1) nvalid++;
        if (one_k_samples === 1'b1) nonek++;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int v0, k0;
    logic [15:0] v;
    bit m;

    do_reset();
    check("reset_avg", 32'(avg_out), 32'h0);

    // Reset while a sample is in ACCUM abandons it and clears sum and buffer.
    send(16'd12, 1'b0, 2, 1'b1);
    check("pre_reset_avg", 32'(avg_out), 32'd3);
    send(16'd20, 1'b0, 2, 1'b0);
    @(negedge clk);
    do_reset();
    check("mid_reset_avg", 32'(avg_out), 32'h0);
    send(16'd8, 1'b0, 2, 1'b1);
    check("after_reset_avg", 32'(avg_out), 32'd2);

    // Sliding window ramp; five samples since reset also produce one counter pulse.
    do_reset();
    v0 = nvalid;
    k0 = nonek;
    send(16'd4, 1'b0, 2, 1'b1);  check("slide1", 32'(avg_out), 32'd1);
    send(16'd8, 1'b0, 3, 1'b1);  check("slide2", 32'(avg_out), 32'd3);
    send(16'd12, 1'b0, 2, 1'b1); check("slide3", 32'(avg_out), 32'd6);
    send(16'd16, 1'b0, 4, 1'b1); check("slide4", 32'(avg_out), 32'd10);
    send(16'd20, 1'b0, 2, 1'b1); check("slide5", 32'(avg_out), 32'd14);
    check("slide_valid_count", 32'(nvalid - v0), 32'd5);
    check("slide_onek_count", 32'(nonek - k0), 32'd1);

    // Block mode, then a mode change clears the buffer.
    do_reset();
    v0 = nvalid;
    send(16'd100, 1'b1, 2, 1'b1);
    send(16'd200, 1'b1, 2, 1'b1);
    send(16'd300, 1'b1, 2, 1'b1);
    send(16'd400, 1'b1, 2, 1'b1); check("block_avg", 32'(avg_out), 32'd250);
    send(16'd10, 1'b1, 2, 1'b1);  check("block_hold", 32'(avg_out), 32'd250);
    check("block_valid_count", 32'(nvalid - v0), 32'd1);
    send(16'd40, 1'b0, 2, 1'b1);  check("mode_switch", 32'(avg_out), 32'd10);

    // Full-scale samples must not wrap the sum.
    do_reset();
    repeat (4) send(16'hFFFF, 1'b0, 2, 1'b1);
    check("width_max", 32'(avg_out), 32'hFFFF);
    send(16'h0000, 1'b0, 2, 1'b1);
    check("width_drop", 32'(avg_out), 32'hBFFF);

    // Dropped sample: value ignored, err set, not counted.
    do_reset();
    k0 = nonek;
    send(16'd40, 1'b0, 2, 1'b1);
    pair(16'd80, 16'd4000, 1'b0, 2);
    check("drop_avg", 32'(avg_out), 32'd30);
    check("drop_err", 32'(err), 32'd1);
    send(16'd0, 1'b0, 2, 1'b1);
    check("drop_err_clear", 32'(err), 32'd0);
    check("drop_avg2", 32'(avg_out), 32'd30);
    send(16'd4, 1'b0, 2, 1'b1);
    check("drop_onek_early", 32'(nonek - k0), 32'd0);
    send(16'd4, 1'b0, 2, 1'b1);
    check("drop_onek_count", 32'(nonek - k0), 32'd1);

    // Back-to-back acceptance.
    do_reset();
    pair(16'd40, 16'd80, 1'b0, 3);
    check("b2b_avg", 32'(avg_out), 32'd30);

    // Randomised traffic against the model.
    do_reset();
    m = 1'b0;
    for (int it = 0; it < 90; it++) begin
      int op;
      op = int'($urandom_range(0, 19));
      if ($urandom_range(0, 7) == 0) m = ~m;
      v = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
      if (op < 13) send(v, m, int'($urandom_range(2, 4)), 1'b1);
      else if (op < 16) pair(v, 16'($urandom), m, 2);
      else if (op < 19) pair(v, 16'($urandom), m, 3);
      else do_reset();
    end
    repeat (4) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
